// File: rtl/block_ram_arbiter_pkg.sv
// Shared constants for block_ram_arbiter: FSM state encoding and requester port indices.
package block_ram_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

endpackage

// File: rtl/block_ram_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
// Grants are combinational; the last-winner register moves only on a grant.
module rr_arb2
  import block_ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // 1 = port B won the most recent grant
  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt[PORT_B];
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt[PORT_A] = 1'b1;
        2'b10:   gnt[PORT_B] = 1'b1;
        2'b11:   if (last) gnt[PORT_A] = 1'b1;
                 else      gnt[PORT_B] = 1'b1;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/block_ram_arbiter.sv
// Round-robin sharing of one single-port block RAM between requesters A and B.
// Define BLOCK_RAM_ARBITER_INIT_EN to clear the whole RAM after every reset.
//
// state   | meaning
// ST_INIT | clear sweep writing INIT_VALUE to every address, requests blocked
// ST_RUN  | arbitrating requests from A and B
module block_ram_arbiter
  import block_ram_arbiter_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 4,
  parameter int                   RAM_WIDTH  = 8,
  parameter int                   RAM_DEPTH  = 16,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_wen,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [RAM_WIDTH-1:0]  a_wdata,
  output logic                  a_rsp_valid,
  output logic [RAM_WIDTH-1:0]  a_rsp_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_wen,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [RAM_WIDTH-1:0]  b_wdata,
  output logic                  b_rsp_valid,
  output logic [RAM_WIDTH-1:0]  b_rsp_rdata,
  output logic                  init_done,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]  ram_wdata,
  input  logic [RAM_WIDTH-1:0]  ram_rdata
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  sweep_active;
  logic                  run_en;
  logic [1:0]            req;
  logic [1:0]            gnt;

`ifdef BLOCK_RAM_ARBITER_INIT_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] clr_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_INIT: begin
        if (clr_cnt == LAST_ADDR) state_nxt   = ST_RUN;
        else                      clr_cnt_nxt = clr_cnt + 1'b1;
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  assign sweep_addr = clr_cnt;
`else
  logic unused_cfg;

  assign state      = ST_RUN;
  assign sweep_addr = '0;
  assign unused_cfg = ^{INIT_VALUE, RAM_DEPTH};
`endif

  // Reset forces every RAM-side and handshake output low, whatever the state.
  assign sweep_active = !rst && (state == ST_INIT);
  assign run_en       = !rst && (state == ST_RUN);
  assign init_done    = (state == ST_RUN);

  assign req = {b_valid, a_valid};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (run_en),
    .gnt (gnt)
  );

  assign a_ready = gnt[PORT_A];
  assign b_ready = gnt[PORT_B];

  always_comb begin
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (sweep_active) begin
      ram_wen   = 1'b1;
      ram_addr  = sweep_addr;
      ram_wdata = INIT_VALUE;
    end else if (gnt[PORT_A]) begin
      ram_wen   = a_wen;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end else if (gnt[PORT_B]) begin
      ram_wen   = b_wen;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
    end else begin
      a_rsp_valid <= gnt[PORT_A] && !a_wen;
      b_rsp_valid <= gnt[PORT_B] && !b_wen;
    end
  end

  assign a_rsp_rdata = ram_rdata;
  assign b_rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Self-checking bench for block_ram_arbiter: bench-side block RAM, per-cycle reference model,
// directed literal checks and a randomized phase. Honours BLOCK_RAM_ARBITER_INIT_EN.
module tb_block_ram_arbiter;

  localparam int       AW    = 4;
  localparam int       DW    = 8;
  localparam int       DEPTH = 16;
  localparam logic [7:0] INITV = 8'h00;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready, a_wen, a_rsp_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rsp_rdata;
  logic          b_valid, b_ready, b_wen, b_rsp_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rsp_rdata;
  logic          init_done, ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  block_ram_arbiter #(
    .ADDR_WIDTH (AW),
    .RAM_WIDTH  (DW),
    .RAM_DEPTH  (DEPTH),
    .INIT_VALUE (INITV)
  ) dut (
    .clk (clk), .rst (rst),
    .a_valid (a_valid), .a_ready (a_ready), .a_wen (a_wen), .a_addr (a_addr),
    .a_wdata (a_wdata), .a_rsp_valid (a_rsp_valid), .a_rsp_rdata (a_rsp_rdata),
    .b_valid (b_valid), .b_ready (b_ready), .b_wen (b_wen), .b_addr (b_addr),
    .b_wdata (b_wdata), .b_rsp_valid (b_rsp_valid), .b_rsp_rdata (b_rsp_rdata),
    .init_done (init_done), .ram_wen (ram_wen), .ram_addr (ram_addr),
    .ram_wdata (ram_wdata), .ram_rdata (ram_rdata)
  );

  // Bench-side single-port block RAM: synchronous write, registered read.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 37 + 5);
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the memory should hold, who won last, what responses are owed.
  logic [DW-1:0] ref_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i * 37 + 5);
  logic          last_b, pend_a, pend_b;
  logic [DW-1:0] pend_a_data, pend_b_data;
  int            cyc;

  always @(negedge clk) begin
    logic          in_init, ga, gb, exp_wen;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    if (rst) begin
      last_b = 1'b1;
      pend_a = 1'b0;
      pend_b = 1'b0;
      cyc    = 0;
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_a_rsp_valid", a_rsp_valid, 0);
      chk("rst_b_rsp_valid", b_rsp_valid, 0);
      chk("rst_ram_wen", ram_wen, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
    end else begin
      in_init = 1'b0;
`ifdef BLOCK_RAM_ARBITER_INIT_EN
      in_init = (cyc < DEPTH);
`endif
      chk("init_done", init_done, !in_init);
      chk("a_rsp_valid", a_rsp_valid, pend_a);
      chk("b_rsp_valid", b_rsp_valid, pend_b);
      if (pend_a) chk("a_rsp_rdata", a_rsp_rdata, pend_a_data);
      if (pend_b) chk("b_rsp_rdata", b_rsp_rdata, pend_b_data);
      ga = 1'b0; gb = 1'b0;
      exp_wen = 1'b0; exp_addr = '0; exp_wd = '0;
      if (in_init) begin
        exp_wen  = 1'b1;
        exp_addr = AW'(cyc);
        exp_wd   = INITV;
        ref_mem[cyc] = INITV;
      end else begin
        ga = a_valid && (!b_valid || last_b);
        gb = b_valid && !ga;
        if (ga) begin exp_wen = a_wen; exp_addr = a_addr; exp_wd = a_wdata; end
        if (gb) begin exp_wen = b_wen; exp_addr = b_addr; exp_wd = b_wdata; end
      end
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
      chk("ram_wen", ram_wen, exp_wen);
      chk("ram_addr", ram_addr, exp_addr);
      chk("ram_wdata", ram_wdata, exp_wd);
      pend_a      = ga && !a_wen;
      pend_b      = gb && !b_wen;
      pend_a_data = ref_mem[a_addr];
      pend_b_data = ref_mem[b_addr];
      if (ga && a_wen) ref_mem[a_addr] = a_wdata;
      if (gb && b_wen) ref_mem[b_addr] = b_wdata;
      if (ga) last_b = 1'b0;
      else if (gb) last_b = 1'b1;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic w, input int ad, input logic [DW-1:0] d);
    a_valid = v; a_wen = w; a_addr = AW'(ad); a_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic w, input int ad, input logic [DW-1:0] d);
    b_valid = v; b_wen = w; b_addr = AW'(ad); b_wdata = d;
  endtask

  logic [DW-1:0] bb_data [3];

  initial begin
    bb_data[0] = 8'h11; bb_data[1] = 8'h22; bb_data[2] = 8'h33;
    rst = 1'b1;
    set_a(1, 0, 0, 0);
    set_b(1, 0, 0, 0);
    #3;
    chk("lit_rst_a_ready", a_ready, 0);
    chk("lit_rst_ram_wen", ram_wen, 0);
`ifdef BLOCK_RAM_ARBITER_INIT_EN
    chk("lit_rst_init_done", init_done, 0);
`else
    chk("lit_rst_init_done", init_done, 1);
`endif
    step(); step();
    set_b(0, 0, 0, 0);
`ifdef BLOCK_RAM_ARBITER_INIT_EN
    set_b(1, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      at_neg();
      chk("lit_sweep_addr", ram_addr, i);
      chk("lit_sweep_wen", ram_wen, 1);
      chk("lit_sweep_a_ready", a_ready, 0);
      if (i < 7) step();
    end
    rst = 1'b1;
    #1;
    chk("lit_midrst_ram_wen", ram_wen, 0);
    chk("lit_midrst_ram_addr", ram_addr, 0);
    chk("lit_midrst_init_done", init_done, 0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      at_neg();
      chk("lit_resweep_addr", ram_addr, i);
      chk("lit_resweep_init_done", init_done, 0);
      step();
    end
    at_neg();
    chk("lit_sweep_done", init_done, 1);
    chk("lit_first_a_ready", a_ready, 1);
    step();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    step(); step();
`else
    rst = 1'b0;
    at_neg();
    chk("lit_first_a_ready", a_ready, 1);
    chk("lit_first_ram_addr", ram_addr, 0);
    chk("lit_first_init_done", init_done, 1);
    step();
    set_a(0, 0, 0, 0);
    at_neg();
    chk("lit_first_rsp_valid", a_rsp_valid, 1);
    chk("lit_first_rsp_data", a_rsp_rdata, 5);
    step();
`endif

    // Single port: write then read back.
    set_a(1, 1, 3, 8'h5A); step();
    set_a(1, 0, 3, 8'h00);
    at_neg();
    chk("lit_wr_no_rsp", a_rsp_valid, 0);
    step();
    set_a(0, 0, 0, 0);
    at_neg();
    chk("lit_single_rsp_valid", a_rsp_valid, 1);
    chk("lit_single_rsp_data", a_rsp_rdata, 8'h5A);
    chk("lit_single_b_rsp", b_rsp_valid, 0);
    step();

    // Contention: last winner is B after these writes, so A takes the first tie.
    set_a(1, 1, 1, 8'hA1); step();
    set_a(0, 0, 0, 0);
    set_b(1, 1, 2, 8'hB2); step();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        set_a(1, 0, 1, 0);
        set_b(1, 0, 2, 0);
      end else begin
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
      end
      at_neg();
      if (i < 4) begin
        chk("lit_tie_a_ready", a_ready, (i % 2 == 0));
        chk("lit_tie_b_ready", b_ready, (i % 2 == 1));
      end
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          chk("lit_tie_a_rsp", a_rsp_valid, 1);
          chk("lit_tie_a_data", a_rsp_rdata, 8'hA1);
        end else begin
          chk("lit_tie_b_rsp", b_rsp_valid, 1);
          chk("lit_tie_b_data", b_rsp_rdata, 8'hB2);
        end
      end
      step();
    end

    // Back-to-back writes then reads on port A.
    for (int i = 0; i < 8; i++) begin
      if (i < 3)      set_a(1, 1, 4 + i, bb_data[i]);
      else if (i < 6) set_a(1, 0, 1 + i, 0);
      else            set_a(0, 0, 0, 0);
      at_neg();
      if (i < 6) chk("lit_b2b_ready", a_ready, 1);
      if (i >= 4 && i <= 6) begin
        chk("lit_b2b_rsp", a_rsp_valid, 1);
        chk("lit_b2b_data", a_rsp_rdata, bb_data[i - 4]);
      end
      step();
    end

    // Randomized traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 400; i++) begin
      set_a($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1), DW'($urandom));
      set_b($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1), DW'($urandom));
      step();
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
